// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the multi-cycle ULA: opcode encodings, FSM state
// encoding and a small helper that decides whether an accepted request
// needs the iterative datapath.
// ---------------------------------------------------------------------------
package ula_pkg;

   // Opcodes 000/001 keep the meaning of the old single-cycle OpULA 0/1
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   // MUL always iterates; DIV only iterates when there is a real divisor,
   // a zero divisor is answered immediately with the div_zero result.
   function automatic logic is_iterative(input logic [2:0] op, input logic b_nonzero);
      return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
   endfunction

endpackage

// File: rtl/ula_iter_core.sv
// ---------------------------------------------------------------------------
// ula_iter_core
// Iterative unsigned multiply / divide datapath shared by MUL and DIV.
//   MUL: shift-add, {hi,lo} starts as {0,a}, b is the multiplicand.
//        After WIDTH steps {hi,lo} is the 2*WIDTH-bit product.
//   DIV: restoring division, {hi,lo} starts as {0,a}, b is the divisor.
//        After WIDTH steps lo is the quotient and hi the remainder.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   load              : capture operands and mode, clear the accumulator
//   step              : perform one iteration
//   div_mode_in       : 1 = divide, 0 = multiply (sampled on load)
//   a, b              : operands (sampled on load)
//   lo, hi            : current low/high registers
//   lo_next, hi_next  : value the registers take on the next step, so the
//                       controller can capture the final result on the
//                       same edge as the last iteration
// ---------------------------------------------------------------------------
module ula_iter_core
   import ula_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo_next,
   output logic [WIDTH-1:0] hi_next
);

   logic [WIDTH-1:0] divisor;
   logic             div_mode;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   shifted;
   logic             fits;

   // Next-step computation for both algorithms. For MUL the multiplier bit
   // leaving lo[0] decides whether the multiplicand is added into hi, then
   // the whole {carry,hi,lo} shifts right. For DIV the next dividend bit is
   // shifted into the partial remainder and the divisor is subtracted only
   // when it fits, which sets the new quotient bit.
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
      shifted = {hi, lo[WIDTH-1]};
      fits    = (shifted >= {1'b0, divisor});
      lo_next = lo;
      hi_next = hi;
      if (div_mode) begin
         if (fits) begin
            hi_next = WIDTH'(shifted - {1'b0, divisor});
            lo_next = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_next = shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_next = mul_sum[WIDTH:1];
         lo_next = {mul_sum[0], lo[WIDTH-1:1]};
      end
   end

   // Register update: load has priority over step so a new operation always
   // starts from a clean accumulator.
   always_ff @(posedge clock) begin
      if (reset) begin
         lo       <= '0;
         hi       <= '0;
         divisor  <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         lo       <= a;
         hi       <= '0;
         divisor  <= b;
         div_mode <= div_mode_in;
      end else if (step) begin
         lo <= lo_next;
         hi <= hi_next;
      end
   end

endmodule

// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
// Parametrised multi-cycle ULA for the nRisc datapath. Single-cycle ops
// (ADD, SUB, AND, OR, SLT, SHL, DIV by zero) answer on the edge after start;
// MUL and DIV run WIDTH iterations in ula_iter_core behind busy.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : request, only looked at while busy = 0
//   op, a, b     : opcode and operands, latched on an accepted start
//   result       : low result word (quotient for DIV)
//   result_hi    : MUL high word / DIV remainder, 0 for other ops
//   zero         : result == 0 (MUL: whole product == 0)
//   carry        : ADD carry-out / SUB borrow
//   overflow     : ADD/SUB signed overflow, MUL high word nonzero
//   div_zero     : DIV with b = 0
//   busy         : iterative op in progress
//   done         : one-cycle pulse, outputs valid from this cycle
// ---------------------------------------------------------------------------
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             div_zero,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);
   localparam int               MSB  = WIDTH - 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mul_q;

   logic             iter_req;
   logic             core_load;
   logic             core_step;
   logic [WIDTH-1:0] core_lo;
   logic [WIDTH-1:0] core_hi;
   logic [WIDTH-1:0] core_lo_next;
   logic [WIDTH-1:0] core_hi_next;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH-1:0] shamt;
   logic [WIDTH-1:0] s_res;
   logic [WIDTH-1:0] s_hi;
   logic             s_zero;
   logic             s_carry;
   logic             s_ovf;
   logic             s_dz;
   logic             i_zero;
   logic             i_ovf;

   // Request decode and core controls. The core is loaded only on the edge
   // that accepts an iterative op and steps every EXEC cycle.
   always_comb begin
      iter_req  = is_iterative(op, |b);
      core_load = (state == ST_IDLE) && start && iter_req;
      core_step = (state == ST_EXEC);
   end

   ula_iter_core #(.WIDTH(WIDTH)) u_core (
      .clock       (clock),
      .reset       (reset),
      .load        (core_load),
      .step        (core_step),
      .div_mode_in (op == OP_DIV),
      .a           (a),
      .b           (b),
      .lo          (core_lo),
      .hi          (core_hi),
      .lo_next     (core_lo_next),
      .hi_next     (core_hi_next)
   );

   // Single-cycle results and flags, computed straight from the live inputs
   // because they are only captured on the accepting edge. Carry for SUB is
   // the borrow out of the extended subtraction, which equals a < b unsigned.
   always_comb begin
      add_full = {1'b0, a} + {1'b0, b};
      sub_full = {1'b0, a} - {1'b0, b};
      shamt    = b % WVAL;
      s_res    = '0;
      s_hi     = '0;
      s_carry  = 1'b0;
      s_ovf    = 1'b0;
      s_dz     = 1'b0;
      case (op)
         OP_ADD: begin
            s_res   = add_full[WIDTH-1:0];
            s_carry = add_full[WIDTH];
            s_ovf   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
         end
         OP_SUB: begin
            s_res   = sub_full[WIDTH-1:0];
            s_carry = sub_full[WIDTH];
            s_ovf   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
         end
         OP_AND: s_res = a & b;
         OP_OR:  s_res = a | b;
         OP_SLT: s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SHL: s_res = a << shamt;
         OP_DIV: begin
            s_res = '1;
            s_hi  = a;
            s_dz  = 1'b1;
         end
         default: s_res = '0;
      endcase
      s_zero = (s_res == '0);
   end

   // Flags for the iterative ops use the core's next value, since the final
   // iteration and the output capture happen on the same edge.
   always_comb begin
      i_zero = mul_q ? ((core_lo_next == '0) && (core_hi_next == '0))
                     : (core_lo_next == '0);
      i_ovf  = mul_q && (core_hi_next != '0);
   end

   // Control FSM and output registers. Outputs change only on a done edge
   // (or reset), so they hold through EXEC. A start seen in EXEC is simply
   // not decoded, which makes it side-effect free.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mul_q     <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         div_zero  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (iter_req) begin
                     state <= ST_EXEC;
                     busy  <= 1'b1;
                     cnt   <= CNT_W'(WIDTH);
                     mul_q <= (op == OP_MUL);
                  end else begin
                     result    <= s_res;
                     result_hi <= s_hi;
                     zero      <= s_zero;
                     carry     <= s_carry;
                     overflow  <= s_ovf;
                     div_zero  <= s_dz;
                     done      <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result    <= core_lo_next;
                  result_hi <= core_hi_next;
                  zero      <= i_zero;
                  carry     <= 1'b0;
                  overflow  <= i_ovf;
                  div_zero  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo
// Directed bench for ula_multiciclo with one WIDTH=8 and one WIDTH=16
// instance. Each test task drives its scenario and compares outputs against
// hand-computed values at the falling edge.
// ---------------------------------------------------------------------------
module tb_ula_multiciclo;
   import ula_pkg::*;

   logic        clock;
   logic        reset;

   logic        start8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8;
   logic [7:0]  result8, hi8;
   logic        zero8, carry8, ovf8, dz8, busy8, done8;

   logic        start16;
   logic [2:0]  op16;
   logic [15:0] a16, b16;
   logic [15:0] result16, hi16;
   logic        zero16, carry16, ovf16, dz16, busy16, done16;

   int checks = 0;
   int passed = 0;

   ula_multiciclo #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .result(result8), .result_hi(hi8), .zero(zero8), .carry(carry8),
      .overflow(ovf8), .div_zero(dz8), .busy(busy8), .done(done8)
   );

   ula_multiciclo #(.WIDTH(16)) dut16 (
      .clock(clock), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
      .result(result16), .result_hi(hi16), .zero(zero16), .carry(carry16),
      .overflow(ovf16), .div_zero(dz16), .busy(busy16), .done(done16)
   );

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Issue one request to the 8-bit instance at a falling edge and wait for
   // done. lat counts falling edges from the request to the done cycle.
   // If poke > 0, a bogus ADD request with new operands is pulsed at that
   // cycle and the visible result is recorded in mid_res.
   task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                input int poke, output int lat, output int busy_n,
                                output logic [7:0] mid_res);
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      lat = 99; busy_n = 0; mid_res = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         start8 = 1'b0;
         if (i == poke) begin
            start8 = 1'b1; op8 = OP_ADD; a8 = 8'h11; b8 = 8'h22;
            mid_res = result8;
         end
         if (busy8) busy_n++;
         if (done8) begin
            lat = i;
            break;
         end
      end
      start8 = 1'b0;
   endtask

   task automatic applyStimulus16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output int lat);
      op16 = o; a16 = x; b16 = y; start16 = 1'b1;
      lat = 99;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         start16 = 1'b0;
         if (done16) begin
            lat = i;
            break;
         end
      end
      start16 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (result8 !== 8'h00) $display("[TB] FAIL reset_result got %h want 00", result8); else passed++;
      checks++; if (hi8 !== 8'h00) $display("[TB] FAIL reset_result_hi got %h want 00", hi8); else passed++;
      checks++; if ({zero8, carry8, ovf8, dz8, busy8, done8} !== 6'b0)
         $display("[TB] FAIL reset_flags got %b want 000000", {zero8, carry8, ovf8, dz8, busy8, done8}); else passed++;
      checks++; if ({busy16, done16, result16} !== 18'h0)
         $display("[TB] FAIL reset_w16 got %h want 0", {busy16, done16, result16}); else passed++;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_add();
      int lat, bn;
      logic [7:0] m;
      applyStimulus(OP_ADD, 8'h01, 8'h03, 0, lat, bn, m);
      checks++; if (lat !== 1) $display("[TB] FAIL add_latency got %0d want 1", lat); else passed++;
      checks++; if (result8 !== 8'h04) $display("[TB] FAIL add1_result got %h want 04", result8); else passed++;
      checks++; if ({zero8, carry8, ovf8} !== 3'b000)
         $display("[TB] FAIL add1_flags got %b want 000", {zero8, carry8, ovf8}); else passed++;
      @(negedge clock);
      checks++; if (done8 !== 1'b0) $display("[TB] FAIL done_pulse_width got %b want 0", done8); else passed++;
      applyStimulus(OP_ADD, 8'hFF, 8'h01, 0, lat, bn, m);
      checks++; if (result8 !== 8'h00) $display("[TB] FAIL add2_result got %h want 00", result8); else passed++;
      checks++; if ({zero8, carry8, ovf8} !== 3'b110)
         $display("[TB] FAIL add2_flags got %b want 110", {zero8, carry8, ovf8}); else passed++;
   endtask

   task automatic test_sub();
      int lat, bn;
      logic [7:0] m;
      applyStimulus(OP_SUB, 8'h80, 8'h01, 0, lat, bn, m);
      checks++; if (result8 !== 8'h7F) $display("[TB] FAIL sub1_result got %h want 7f", result8); else passed++;
      checks++; if ({zero8, carry8, ovf8} !== 3'b001)
         $display("[TB] FAIL sub1_flags got %b want 001", {zero8, carry8, ovf8}); else passed++;
      applyStimulus(OP_SUB, 8'h01, 8'h03, 0, lat, bn, m);
      checks++; if (result8 !== 8'hFE) $display("[TB] FAIL sub2_result got %h want fe", result8); else passed++;
      checks++; if ({zero8, carry8, ovf8} !== 3'b010)
         $display("[TB] FAIL sub2_flags got %b want 010", {zero8, carry8, ovf8}); else passed++;
   endtask

   task automatic test_logic();
      int lat, bn;
      logic [7:0] m;
      applyStimulus(OP_AND, 8'hF0, 8'h3C, 0, lat, bn, m);
      checks++; if (result8 !== 8'h30) $display("[TB] FAIL and_result got %h want 30", result8); else passed++;
      applyStimulus(OP_OR, 8'hF0, 8'h0C, 0, lat, bn, m);
      checks++; if (result8 !== 8'hFC) $display("[TB] FAIL or_result got %h want fc", result8); else passed++;
      applyStimulus(OP_SLT, 8'h01, 8'hFF, 0, lat, bn, m);
      checks++; if ({result8, zero8} !== {8'h00, 1'b1})
         $display("[TB] FAIL slt_false got %h/%b want 00/1", result8, zero8); else passed++;
      applyStimulus(OP_SHL, 8'h03, 8'h09, 0, lat, bn, m);
      checks++; if (result8 !== 8'h06) $display("[TB] FAIL shl_mod_result got %h want 06", result8); else passed++;
      checks++; if (hi8 !== 8'h00) $display("[TB] FAIL shl_result_hi got %h want 00", hi8); else passed++;
   endtask

   task automatic test_mul_ignore();
      int lat, bn;
      logic [7:0] m;
      applyStimulus(OP_MUL, 8'h10, 8'h20, 3, lat, bn, m);
      checks++; if (lat !== 9) $display("[TB] FAIL mul_latency got %0d want 9", lat); else passed++;
      checks++; if (bn !== 8) $display("[TB] FAIL mul_busy_cycles got %0d want 8", bn); else passed++;
      checks++; if (m !== 8'h06) $display("[TB] FAIL mul_hold_during_exec got %h want 06", m); else passed++;
      checks++; if ({hi8, result8} !== 16'h0200)
         $display("[TB] FAIL mul_product got %h want 0200", {hi8, result8}); else passed++;
      checks++; if ({zero8, carry8, ovf8, busy8} !== 4'b0010)
         $display("[TB] FAIL mul_flags got %b want 0010", {zero8, carry8, ovf8, busy8}); else passed++;
      @(negedge clock);
      checks++; if (done8 !== 1'b0) $display("[TB] FAIL mul_ignored_start got done %b want 0", done8); else passed++;
   endtask

   task automatic test_div();
      int lat, bn;
      logic [7:0] m;
      applyStimulus(OP_DIV, 8'hC8, 8'h07, 0, lat, bn, m);
      checks++; if (lat !== 9) $display("[TB] FAIL div_latency got %0d want 9", lat); else passed++;
      checks++; if ({result8, hi8} !== 16'h1C04)
         $display("[TB] FAIL div_quot_rem got %h want 1c04", {result8, hi8}); else passed++;
      checks++; if ({zero8, ovf8, dz8} !== 3'b000)
         $display("[TB] FAIL div_flags got %b want 000", {zero8, ovf8, dz8}); else passed++;
      applyStimulus(OP_DIV, 8'h05, 8'h00, 0, lat, bn, m);
      checks++; if (lat !== 1) $display("[TB] FAIL div0_latency got %0d want 1", lat); else passed++;
      checks++; if ({result8, hi8} !== 16'hFF05)
         $display("[TB] FAIL div0_result got %h want ff05", {result8, hi8}); else passed++;
      checks++; if ({zero8, dz8} !== 2'b01)
         $display("[TB] FAIL div0_flags got %b want 01", {zero8, dz8}); else passed++;
   endtask

   task automatic test_reset_mid_exec();
      int lat, bn;
      logic [7:0] m;
      logic saw_done;
      saw_done = 1'b0;
      op8 = OP_MUL; a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         start8 = 1'b0;
         if (done8) saw_done = 1'b1;
      end
      reset = 1'b1;
      @(negedge clock);
      if (done8) saw_done = 1'b1;
      checks++; if ({busy8, result8, hi8} !== 17'h0)
         $display("[TB] FAIL rst_mid_outputs got %h want 0", {busy8, result8, hi8}); else passed++;
      checks++; if ({zero8, carry8, ovf8, dz8} !== 4'b0)
         $display("[TB] FAIL rst_mid_flags got %b want 0000", {zero8, carry8, ovf8, dz8}); else passed++;
      reset = 1'b0;
      repeat (10) begin
         @(negedge clock);
         if (done8) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) $display("[TB] FAIL rst_mid_no_done got %b want 0", saw_done); else passed++;
      applyStimulus(OP_MUL, 8'h03, 8'h05, 0, lat, bn, m);
      checks++; if ({lat, hi8, result8, ovf8} !== {32'd9, 16'h000F, 1'b0})
         $display("[TB] FAIL rst_mid_restart got lat %0d prod %h ovf %b want 9 000f 0", lat, {hi8, result8}, ovf8);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, bn;
      logic [7:0] m;
      applyStimulus(OP_DIV, 8'hC8, 8'h07, 0, lat, bn, m);
      applyStimulus(OP_SLT, 8'hFF, 8'h01, 0, lat, bn, m);
      checks++; if (lat !== 1) $display("[TB] FAIL b2b_latency got %0d want 1", lat); else passed++;
      checks++; if ({result8, hi8, zero8} !== {16'h0100, 1'b0})
         $display("[TB] FAIL b2b_slt got %h/%h/%b want 01/00/0", result8, hi8, zero8); else passed++;
   endtask

   task automatic test_width16();
      int lat;
      applyStimulus16(OP_MUL, 16'h1234, 16'h0100, lat);
      checks++; if (lat !== 17) $display("[TB] FAIL w16_mul_latency got %0d want 17", lat); else passed++;
      checks++; if ({hi16, result16, ovf16} !== {32'h0012_3400, 1'b1})
         $display("[TB] FAIL w16_mul got %h ovf %b want 00123400 1", {hi16, result16}, ovf16); else passed++;
      applyStimulus16(OP_DIV, 16'hFFFF, 16'h0010, lat);
      checks++; if (lat !== 17) $display("[TB] FAIL w16_div_latency got %0d want 17", lat); else passed++;
      checks++; if ({result16, hi16} !== 32'h0FFF_000F)
         $display("[TB] FAIL w16_div got %h want 0fff000f", {result16, hi16}); else passed++;
   endtask

   // Test sequence
   initial begin
      reset = 1'b1;
      start8 = 1'b0; op8 = OP_ADD; a8 = '0; b8 = '0;
      start16 = 1'b0; op16 = OP_ADD; a16 = '0; b16 = '0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_mul_ignore();
      test_div();
      test_reset_mid_exec();
      test_back_to_back();
      test_width16();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
